// File: rtl/mdio_pkg.sv
// Shared MDIO definitions: poller FSM states, Clause-22 frame constants and the
// 2-bit link-speed encoding also used by rgmii_phy_if.
package mdio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    HDR,
    TA,
    DATA,
    UPDATE
  } mdio_state_t;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;

  // Index of the last bit in each frame section (bit counter counts from 0).
  localparam logic [4:0] PRE_LAST  = 5'd31;
  localparam logic [4:0] HDR_LAST  = 5'd13;
  localparam logic [4:0] TA_LAST   = 5'd1;
  localparam logic [4:0] DATA_LAST = 5'd15;

  localparam logic [1:0] SPEED_1G   = 2'b10;
  localparam logic [1:0] SPEED_100M = 2'b01;
  localparam logic [1:0] SPEED_10M  = 2'b00;

  // Serialised MSB-first after the preamble: ST, OP, PHY address, register.
  function automatic logic [13:0] rd_header(input logic [4:0] phy, input logic [4:0] reg_a);
    return {MDIO_ST, MDIO_OP_RD, phy, reg_a};
  endfunction

  // The speed field is only trusted with link up; the reserved code keeps the old value.
  function automatic logic [1:0] next_speed(input logic link, input logic [1:0] fld,
                                            input logic [1:0] cur);
    logic [1:0] res;
    res = cur;
    if (link) begin
      case (fld)
        SPEED_1G, SPEED_100M, SPEED_10M: res = fld;
        default:                         res = cur;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/mdio_bit_tick.sv
// MDC generator: one bit period is 2*MDC_DIV clk cycles, mdc low then high.
// Strobes mark bit start (mdc falling), the sample cycle (mdc rising) and the last cycle.
module mdio_bit_tick #(
  parameter int MDC_DIV = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic mdc,
  output logic bit_start,
  output logic sample,
  output logic bit_end
);

  localparam int            CW   = $clog2(2 * MDC_DIV);
  localparam logic [CW-1:0] HALF = CW'(MDC_DIV);
  localparam logic [CW-1:0] LAST = CW'(2 * MDC_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mdc_q, mdc_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = '0;
    mdc_d = 1'b0;
    if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      mdc_d = (cnt_d >= HALF);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end

  assign mdc       = mdc_q;
  assign bit_start = en && (cnt_q == '0);
  assign sample    = en && (cnt_q == HALF);
  assign bit_end   = en && (cnt_q == LAST);

endmodule

// File: rtl/mdio_speed_poller.sv
// Periodically reads a Clause-22 PHY status register over MDIO and tracks link/speed.
// Option: define MDIO_SPEED_POLLER_PRE_SUPPRESS_EN to send the preamble only when needed.
module mdio_speed_poller
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR      = 5'd0,
  parameter logic [4:0]  STATUS_REG    = 5'd17,
  parameter int          SPEED_MSB     = 15,
  parameter int          LINK_BIT      = 10,
  parameter int          MDC_DIV       = 25,
  parameter logic [31:0] POLL_INTERVAL = 32'd1250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       poll_req,
  output logic       mdc,
  input  logic       mdio_i,
  output logic       mdio_o,
  output logic       mdio_t,
  output logic [1:0] speed,
  output logic       link_up,
  output logic       status_valid,
  output logic       busy,
  output logic       speed_change,
  output logic       rd_err
);

  localparam logic [13:0] HDR_WORD   = rd_header(PHY_ADDR, STATUS_REG);
  localparam logic [3:0]  LINK_IDX   = 4'(LINK_BIT);
  localparam logic [3:0]  SPD_HI_IDX = 4'(SPEED_MSB);
  localparam logic [3:0]  SPD_LO_IDX = 4'(SPEED_MSB - 1);

  mdio_state_t state_q, state_d;
  logic [31:0] ivl_q, ivl_d;
  logic [4:0]  bit_q, bit_d;
  logic        pend_q, pend_d;
  logic        ta_err_q, ta_err_d;
  logic        rx_link_q, rx_link_d;
  logic [1:0]  rx_spd_q, rx_spd_d;
  logic        mdio_o_q, mdio_o_d;
  logic        mdio_t_q, mdio_t_d;
  logic [1:0]  speed_q, speed_d;
  logic        link_q, link_d;
  logic        valid_q, valid_d;

  logic        tick_en, bit_start, sample, bit_end;
  logic [4:0]  last_bit;
  logic [3:0]  data_idx, hdr_idx;
  logic [1:0]  upd_speed;
  mdio_state_t idle_start, upd_start, sect_next;

  assign tick_en = (state_q == PRE) || (state_q == HDR) || (state_q == TA) || (state_q == DATA);

  mdio_bit_tick #(.MDC_DIV(MDC_DIV)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (tick_en),
    .mdc      (mdc),
    .bit_start(bit_start),
    .sample   (sample),
    .bit_end  (bit_end)
  );

`ifdef MDIO_SPEED_POLLER_PRE_SUPPRESS_EN
  // Preamble is needed after reset and after a frame nobody answered.
  logic need_pre_q, need_pre_d;

  always_comb begin
    need_pre_d = need_pre_q;
    if (state_q == UPDATE) need_pre_d = ta_err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) need_pre_q <= 1'b1;
    else        need_pre_q <= need_pre_d;
  end

  assign idle_start = need_pre_q ? PRE : HDR;
  assign upd_start  = ta_err_q ? PRE : HDR;
`else
  assign idle_start = PRE;
  assign upd_start  = PRE;
`endif

  always_comb begin
    case (state_q)
      PRE:     begin last_bit = PRE_LAST;  sect_next = HDR;    end
      HDR:     begin last_bit = HDR_LAST;  sect_next = TA;     end
      TA:      begin last_bit = TA_LAST;   sect_next = DATA;   end
      default: begin last_bit = DATA_LAST; sect_next = UPDATE; end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ivl_d        = ivl_q;
    bit_d        = bit_q;
    pend_d       = pend_q;
    ta_err_d     = ta_err_q;
    rx_link_d    = rx_link_q;
    rx_spd_d     = rx_spd_q;
    mdio_o_d     = mdio_o_q;
    mdio_t_d     = mdio_t_q;
    speed_d      = speed_q;
    link_d       = link_q;
    valid_d      = valid_q;
    speed_change = 1'b0;
    rd_err       = 1'b0;
    data_idx     = 4'd15 - bit_q[3:0];
    hdr_idx      = 4'd13 - bit_q[3:0];
    upd_speed    = next_speed(rx_link_q, rx_spd_q, speed_q);

    case (state_q)
      IDLE: begin
        mdio_o_d = 1'b1;
        mdio_t_d = 1'b1;
        if (poll_req || (ivl_q == POLL_INTERVAL - 32'd1)) begin
          ivl_d   = '0;
          bit_d   = '0;
          state_d = idle_start;
        end else begin
          ivl_d = ivl_q + 32'd1;
        end
      end

      UPDATE: begin
        mdio_o_d = 1'b1;
        mdio_t_d = 1'b1;
        bit_d    = '0;
        pend_d   = 1'b0;
        rd_err   = ta_err_q;
        if (!ta_err_q) begin
          valid_d      = 1'b1;
          link_d       = rx_link_q;
          speed_d      = upd_speed;
          speed_change = (upd_speed != speed_q) || (rx_link_q != link_q);
        end
        // A request seen during the frame chains the next one without an IDLE cycle.
        state_d = (pend_q || poll_req) ? upd_start : IDLE;
      end

      default: begin
        if (poll_req) pend_d = 1'b1;
        if (bit_start) begin
          case (state_q)
            PRE:     begin mdio_o_d = 1'b1;               mdio_t_d = 1'b0; end
            HDR:     begin mdio_o_d = HDR_WORD[hdr_idx];  mdio_t_d = 1'b0; end
            default: begin mdio_o_d = 1'b1;               mdio_t_d = 1'b1; end
          endcase
        end
        if (sample) begin
          // A responding PHY pulls the second turnaround bit low.
          if ((state_q == TA) && bit_q[0]) ta_err_d = mdio_i;
          if (state_q == DATA) begin
            if (data_idx == LINK_IDX)   rx_link_d   = mdio_i;
            if (data_idx == SPD_HI_IDX) rx_spd_d[1] = mdio_i;
            if (data_idx == SPD_LO_IDX) rx_spd_d[0] = mdio_i;
          end
        end
        if (bit_end) begin
          if (bit_q == last_bit) begin
            bit_d   = '0;
            state_d = sect_next;
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ivl_q     <= '0;
      bit_q     <= '0;
      pend_q    <= 1'b0;
      ta_err_q  <= 1'b0;
      rx_link_q <= 1'b0;
      rx_spd_q  <= SPEED_1G;
      mdio_o_q  <= 1'b1;
      mdio_t_q  <= 1'b1;
      speed_q   <= SPEED_1G;
      link_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ivl_q     <= ivl_d;
      bit_q     <= bit_d;
      pend_q    <= pend_d;
      ta_err_q  <= ta_err_d;
      rx_link_q <= rx_link_d;
      rx_spd_q  <= rx_spd_d;
      mdio_o_q  <= mdio_o_d;
      mdio_t_q  <= mdio_t_d;
      speed_q   <= speed_d;
      link_q    <= link_d;
      valid_q   <= valid_d;
    end
  end

  assign mdio_o       = mdio_o_q;
  assign mdio_t       = mdio_t_q;
  assign speed        = speed_q;
  assign link_up      = link_q;
  assign status_valid = valid_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: doc/mdio_speed_poller.md
MDIO_SPEED_POLLER -- requirements
Module: mdio_speed_poller

Interface
REQ-001 SHALL take parameter PHY_ADDR, default 5'd0: Clause-22 PHY address polled.
REQ-002 SHALL take parameter STATUS_REG, default 5'd17: PHY register holding link and speed.
REQ-003 SHALL take parameter SPEED_MSB, default 15: speed field is bits [SPEED_MSB:SPEED_MSB-1], encoded 2'b10 1G, 2'b01 100M, 2'b00 10M.
REQ-004 SHALL take parameter LINK_BIT, default 10: status bit that is 1 when link is up.
REQ-005 SHALL take parameter MDC_DIV, default 25 (minimum 2): MDC half-period in clk cycles.
REQ-006 SHALL take parameter POLL_INTERVAL, default 32'd1250000: clk cycles between automatic polls.
REQ-007 SHALL have port clk, input, 1, sole clock.
REQ-008 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-009 SHALL have ports poll_req (input, 1: pulse requesting an immediate poll), mdc (output, 1: MDIO clock), mdio_i (input, 1: sampled MDIO pad), mdio_o (output, 1: driven MDIO value) and mdio_t (output, 1: 1 = pad released/high-Z).
REQ-010 SHALL have ports speed (output, 2: rgmii_phy_if encoding), link_up (output, 1), status_valid (output, 1: at least one good read completed), busy (output, 1: frame in progress), speed_change (output, 1: one-cycle pulse when speed or link_up changes) and rd_err (output, 1: one-cycle pulse when no PHY responded).

Function
REQ-011 SHALL produce mdc as clk/(2*MDC_DIV): one bit period = 2*MDC_DIV clk cycles, mdc low in the first half and high in the second; mdc SHALL stay low while idle.
REQ-012 SHALL update mdio_o/mdio_t at the start of each bit period (mdc falling) and SHALL sample mdio_i on the clk cycle in which mdc rises.
REQ-013 SHALL use FSM states IDLE, PRE, HDR, TA, DATA and UPDATE; frame = PRE 32 ones, HDR 14 bits (01, 10, PHY_ADDR MSB-first, STATUS_REG MSB-first), TA 2 bits released, DATA 16 bits MSB-first released.
REQ-014 In IDLE, an interval counter SHALL increment each cycle; at POLL_INTERVAL-1, or when poll_req=1, the counter SHALL clear and the FSM SHALL enter PRE on the next cycle.
REQ-015 poll_req asserted while busy=1 SHALL set a single pending flag; further requests SHALL coalesce; a pending request SHALL start a new frame directly from UPDATE.
REQ-016 If mdio_i sampled in the second TA bit is 1, the frame SHALL still complete, but UPDATE SHALL pulse rd_err and leave speed, link_up and status_valid unchanged.
REQ-017 On a good read, UPDATE SHALL set status_valid=1 and link_up=data[LINK_BIT]; speed SHALL take the decoded field only when the link bit is 1 and the field is not 2'b11, otherwise it keeps its value.
REQ-018 speed_change SHALL pulse in the UPDATE cycle only if speed or link_up differs from its prior value.
REQ-019 busy SHALL be 1 from the first PRE cycle through the UPDATE cycle inclusive; UPDATE SHALL last exactly one cycle.

Reset
REQ-020 On rst_n=0, asynchronously: state IDLE, mdc=0, mdio_o=1, mdio_t=1, speed=2'b10, link_up=0, status_valid=0, busy=0, speed_change=0, rd_err=0, counters and the pending flag cleared.
REQ-021 Reset mid-frame SHALL abort the frame and release the pad immediately; after rst_n rises, the first automatic poll SHALL start POLL_INTERVAL cycles later.

Configuration
REQ-022 With MDIO_SPEED_POLLER_PRE_SUPPRESS_EN defined, PRE SHALL be emitted only on the first frame after reset and after any rd_err; later frames SHALL go IDLE->HDR. Without it, every frame SHALL carry 32 preamble bits.

Structure
REQ-023 SHALL place the FSM state enum, MDIO ST/OP constants and the speed encoding constants (shared with rgmii_phy_if users) in package mdio_pkg.
REQ-024 SHALL have one sub-module, mdio_bit_tick, generating mdc and the bit-start and sample strobes from MDC_DIV.

Verification
REQ-025 PHY model returns 16'h8400 (link=1, speed=10) -> speed=2'b10, link_up=1, status_valid=1, speed_change pulses once.
REQ-026 Next read returns 16'h4400 -> speed=2'b01, speed_change pulses; a repeat of 16'h4400 -> no pulse.
REQ-027 Read returns 16'h0000 -> link_up=0, speed stays 2'b01, speed_change pulses.
REQ-028 No PHY (mdio_i pulled to 1) -> rd_err pulses, status_valid stays 0, frame length is 64*2*MDC_DIV cycles.
REQ-029 Three poll_req pulses during a frame -> exactly one extra frame, started from UPDATE with no IDLE cycle.
REQ-030 rst_n low during DATA -> mdio_t=1 and mdc=0 in the same cycle; outputs return to reset values; with PRE_SUPPRESS_EN, the first frame after reset carries a preamble.
